arbitro_trasmettitore: RTL and testbench

//  Round-robin arbiter that shares one serial transmitter among N byte producers.

---
 rtl/arbitro_trasmettitore.sv | 122 ++++++++++++
 tb/tb_arbitro_trasmettitore.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_trasmettitore.sv
// Round-robin arbiter sharing one serial transmitter among N byte producers.
// Acts as 4-phase dav_/rfd consumer toward each producer and producer toward the transmitter.
module arbitro_trasmettitore #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N*W-1:0] byte_in,
  input  logic [N-1:0]   dav_in_,
  output logic [N-1:0]   rfd_out,
  input  logic [N-1:0]   mask,
  output logic [W-1:0]   tx_byte,
  output logic           tx_dav_,
  input  logic           tx_rfd,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, REQ, ACK, DONE} state_t;

  state_t        state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] g_q;
  logic [N-1:0]  rfd_q;
  logic [N-1:0]  grant_q;
  logic [W-1:0]  tx_byte_q;
  logic          tx_dav_q;
  logic          busy_q;

  logic [N-1:0]  elig;
  logic [PW-1:0] win_idx;
  logic          win_any;
  logic [PW-1:0] ptr_d;

  assign elig = ~dav_in_ & mask;

  // Scan from the highest offset down so the first eligible channel after ptr wins.
  always_comb begin
    int            j;
    logic [PW-1:0] idx;
    j       = 0;
    idx     = '0;
    win_idx = ptr_q;
    win_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j       = int'(ptr_q) + k;
      j       = (j >= N) ? (j - N) : j;
      idx     = PW'(j);
      win_any = win_any | elig[idx];
      win_idx = elig[idx] ? idx : win_idx;
    end
  end

  assign ptr_d = (g_q == PW'(N - 1)) ? '0 : (g_q + PW'(1));

  // Handshake sequencer; every output is a register updated with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      g_q       <= '0;
      rfd_q     <= '1;
      grant_q   <= '0;
      tx_byte_q <= '0;
      tx_dav_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_dav_q <= 1'b1;
          if (tx_rfd && win_any) begin
            tx_byte_q <= byte_in[win_idx*W +: W];
            grant_q   <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            g_q       <= win_idx;
            tx_dav_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          // Producer dav_ changes are ignored here: the byte is already latched.
          if (!tx_rfd) begin
            tx_dav_q   <= 1'b1;
            rfd_q[g_q] <= 1'b0;
            state_q    <= ACK;
          end
        end
        ACK: begin
          if (dav_in_[g_q]) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (tx_rfd) begin
            rfd_q   <= '1;
            grant_q <= '0;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          rfd_q    <= '1;
          grant_q  <= '0;
          tx_dav_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rfd_out = rfd_q;
  assign tx_byte = tx_byte_q;
  assign tx_dav_ = tx_dav_q;
  assign grant   = grant_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_arbitro_trasmettitore.sv
// Scoreboard bench for arbitro_trasmettitore with behavioural producers and a
// behavioural serial transmitter (start + 8 data bits LSB first + stop, 2 clocks/bit).
module tb_arbitro_trasmettitore;
  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [N*W-1:0] byte_in;
  logic [N-1:0]   dav_in_;
  logic [N-1:0]   rfd_out;
  logic [N-1:0]   mask;
  logic [W-1:0]   tx_byte;
  logic           tx_dav_;
  logic           tx_rfd;
  logic [N-1:0]   grant;
  logic           busy;

  logic tx_model_rfd;
  logic tx_block;
  logic ser;
  logic prev_dav;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]   prod_q [N][$];
  logic [N+W-1:0] exp_q [$];
  logic [W-1:0]   ser_exp [$];
  int             pst [N];

  assign tx_rfd = tx_model_rfd & ~tx_block;

  always #5 clock = ~clock;

  arbitro_trasmettitore #(.N(N), .W(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .byte_in(byte_in),
    .dav_in_(dav_in_),
    .rfd_out(rfd_out),
    .mask   (mask),
    .tx_byte(tx_byte),
    .tx_dav_(tx_dav_),
    .tx_rfd (tx_rfd),
    .grant  (grant),
    .busy   (busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic feed(input int c, input logic [W-1:0] b);
    prod_q[c].push_back(b);
  endtask

  task automatic expect_tx(input int c, input logic [W-1:0] b);
    logic [N-1:0] oh;
    oh = '0;
    oh[c] = 1'b1;
    exp_q.push_back({oh, b});
    ser_exp.push_back(b);
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_rfd_out"}, rfd_out, 4'hF);
    check({nm, "_tx_dav_"}, tx_dav_, 1'b1);
    check({nm, "_tx_byte"}, tx_byte, 8'h00);
    check({nm, "_grant"}, grant, 4'h0);
    check({nm, "_busy"}, busy, 1'b0);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ser_exp.size() != 0 || busy !== 1'b0 ||
            tx_model_rfd !== 1'b1) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check({"drain_", nm}, n < 4000, 1'b1);
    step();
  endtask

  // Producers: 4-phase handshake per channel, one step per negedge.
  initial begin
    dav_in_ = '1;
    byte_in = '0;
    for (int c = 0; c < N; c++) pst[c] = 0;
    forever begin
      @(negedge clock);
      for (int c = 0; c < N; c++) begin
        if (pst[c] == 0) begin
          if (prod_q[c].size() > 0) begin
            byte_in[W*c +: W] = prod_q[c].pop_front();
            dav_in_[c] = 1'b0;
            pst[c] = 1;
          end
        end else if (pst[c] == 1) begin
          if (!rfd_out[c]) begin
            dav_in_[c] = 1'b1;
            pst[c] = 2;
          end
        end else if (rfd_out[c]) begin
          pst[c] = 0;
        end
      end
    end
  end

  // Transmitter model: capture on dav_ low, wait release, shift out one frame, then ready.
  initial begin
    logic [W-1:0] cap;
    int n;
    tx_model_rfd = 1'b1;
    ser = 1'b1;
    forever begin
      @(negedge clock);
      if (!tx_dav_ && tx_model_rfd) begin
        cap = tx_byte;
        tx_model_rfd = 1'b0;
        n = 0;
        while (!tx_dav_ && n < 100) begin
          @(negedge clock);
          n++;
        end
        if (n >= 100) begin
          checks++;
          failures++;
          $display("FAIL tx_dav_release: still low after %0d cycles, required release", n);
        end
        ser = 1'b0;
        repeat (2) @(negedge clock);
        for (int b = 0; b < W; b++) begin
          ser = cap[b];
          repeat (2) @(negedge clock);
        end
        ser = 1'b1;
        repeat (2) @(negedge clock);
        tx_model_rfd = 1'b1;
      end
    end
  end

  // Serial line receiver: mid-bit sampling on posedge.
  initial begin
    logic [W-1:0] got;
    got = '0;
    forever begin
      @(posedge clock);
      if (ser == 1'b0) begin
        for (int b = 0; b < W; b++) begin
          repeat (2) @(posedge clock);
          got[b] = ser;
        end
        repeat (2) @(posedge clock);
        check("stop_bit", ser, 1'b1);
        if (ser_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL serial_extra: got frame %0h, required none", got);
        end else begin
          check("serial_byte", got, ser_exp.pop_front());
        end
      end
    end
  end

  // Scoreboard monitor: each tx_dav_ fall is one transfer offered to the transmitter.
  initial begin
    logic [N+W-1:0] e;
    prev_dav = 1'b1;
    forever begin
      @(negedge clock);
      if (prev_dav === 1'b1 && tx_dav_ === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_extra: got grant=%b byte=%0h, required none", grant, tx_byte);
        end else begin
          e = exp_q.pop_front();
          check("tx_grant", grant, e[N+W-1:W]);
          check("tx_byte", tx_byte, e[W-1:0]);
        end
      end
      prev_dav = tx_dav_;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int bad;
    reset = 1'b1;
    mask = '1;
    tx_block = 1'b0;
    step();
    step();
    @(negedge clock);
    check_reset_values("reset");
    step();
    reset = 1'b0;

    // T1 single request on ch2
    feed(2, 8'hA5);
    expect_tx(2, 8'hA5);
    @(negedge clock);
    @(negedge clock);
    check("t1_tx_dav_low", tx_dav_, 1'b0);
    check("t1_busy", busy, 1'b1);
    check("t1_grant", grant, 4'b0100);
    @(negedge clock);
    check("t1_rfd_out", rfd_out, 4'b1011);
    check("t1_tx_dav_high", tx_dav_, 1'b1);
    drain("t1");

    // T2 contention from reset, then a full round
    reset = 1'b1;
    step();
    reset = 1'b0;
    feed(0, 8'h10); feed(1, 8'h11); feed(3, 8'h13);
    expect_tx(0, 8'h10); expect_tx(1, 8'h11); expect_tx(3, 8'h13);
    drain("t2a");
    for (int c = 0; c < N; c++) begin
      feed(c, 8'(8'h20 + c));
      expect_tx(c, 8'(8'h20 + c));
    end
    drain("t2b");

    // T3 mask blocks ch0 until re-enabled
    mask = 4'b1110;
    feed(0, 8'h30); feed(1, 8'h31);
    expect_tx(1, 8'h31);
    drain("t3a");
    repeat (5) @(negedge clock);
    check("t3_rfd0_held", rfd_out[0], 1'b1);
    check("t3_idle_grant", grant, 4'h0);
    step();
    expect_tx(0, 8'h30);
    mask = 4'b1111;
    drain("t3b");

    // T4 transmitter not ready: no grant
    tx_block = 1'b1;
    feed(1, 8'h41);
    bad = 0;
    repeat (12) begin
      @(negedge clock);
      if (tx_dav_ !== 1'b1 || grant !== 4'h0 || busy !== 1'b0) bad++;
    end
    check("t4_hold_bad_cycles", bad, 0);
    step();
    expect_tx(1, 8'h41);
    tx_block = 1'b0;
    drain("t4");

    // T5 reset while in DONE, then ptr must be back at 0
    feed(2, 8'h52);
    expect_tx(2, 8'h52);
    n = 0;
    while (!(dav_in_[2] === 1'b1 && rfd_out[2] === 1'b0 && pst[2] == 2) && n < 200) begin
      step();
      n++;
    end
    check("t5_reach_done", n < 200, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check_reset_values("t5");
    step();
    feed(1, 8'h61); feed(3, 8'h63);
    expect_tx(1, 8'h61); expect_tx(3, 8'h63);
    drain("t5");

    // T6 three channels x four bytes, round-robin on the serial line
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        feed(c, 8'(8'hA0 + 16 * c + r));
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        expect_tx(c, 8'(8'hA0 + 16 * c + r));
      end
    end
    drain("t6");
    check("final_tx_queue_empty", exp_q.size(), 0);
    check("final_ser_queue_empty", ser_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
